// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: initiator side of the single-write-port CSR file.
// Takes Zicsr / trap ops from the EXU, sequences CSR reads and writes one per
// cycle, returns the old CSR value and issues PC redirects for ECALL / MRET.
//
// Ports:
//   clock, reset (async, active-low)
//   req_*   : EXU request channel (valid/ready), fields registered on accept
//   csr_*_o : CSR file write port and read address; csr_rdata_i is combinational
//   csr_mtvec_i / csr_mepc_i : live trap vector and exception PC
//   resp_*  : response channel, held stable in RESP until resp_ready_i
//
// Optional feature macro: CSR_MSTATUS_TRAP_EN
//   defined   -> ECALL adds a TRAP_STATUS cycle and MRET updates MSTATUS
//   undefined -> traps never touch MSTATUS
module csr_access_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int ECALL_CAUSE = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic              req_imm_i,
  input  logic              req_rs1_zero_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_src_i,
  input  logic [DATA_W-1:0] req_pc_i,
  output logic              csr_we_o,
  output logic [ADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0] csr_wdata_o,
  output logic [ADDR_W-1:0] csr_raddr_o,
  input  logic [DATA_W-1:0] csr_rdata_i,
  input  logic [DATA_W-1:0] csr_mtvec_i,
  input  logic [DATA_W-1:0] csr_mepc_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_redirect_o,
  output logic [DATA_W-1:0] resp_pc_o
);

  localparam logic [2:0] OP_RW    = 3'b001;
  localparam logic [2:0] OP_RS    = 3'b010;
  localparam logic [2:0] OP_RC    = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET  = 3'b101;

  localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(12'h300);
  localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(12'h341);
  localparam logic [ADDR_W-1:0] A_MCAUSE  = ADDR_W'(12'h342);

  typedef enum logic [2:0] {
    IDLE, EXEC, TRAP_EPC, TRAP_CAUSE, TRAP_STATUS, RESP
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic              rs1z_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] src_q, pc_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              redir_q, redir_d;
  logic [DATA_W-1:0] rpc_q, rpc_d;
  logic              accept;

  // zimm arrives already zero-extended in req_src_i, so the flag carries no
  // extra information here.
  logic unused_imm;
  assign unused_imm = req_imm_i;

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;

`ifdef CSR_MSTATUS_TRAP_EN
  // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [DATA_W-1:0] st_enter(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction
  // Trap return: MIE <- MPIE, MPIE <- 1, MPP <- M.
  function automatic logic [DATA_W-1:0] st_leave(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    redir_d     = redir_q;
    rpc_d       = rpc_q;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    csr_raddr_o = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Clear the response fields so ops that return nothing report 0.
          rdata_d = '0;
          redir_d = 1'b0;
          rpc_d   = '0;
          case (req_op_i)
            OP_RW, OP_RS, OP_RC, OP_MRET: state_d = EXEC;
            OP_ECALL:                     state_d = TRAP_EPC;
            default:                      state_d = RESP;
          endcase
        end
      end
      EXEC: begin
        state_d = RESP;
        if (op_q == OP_MRET) begin
          redir_d = 1'b1;
          rpc_d   = csr_mepc_i;
`ifdef CSR_MSTATUS_TRAP_EN
          csr_raddr_o = A_MSTATUS;
          csr_we_o    = 1'b1;
          csr_waddr_o = A_MSTATUS;
          csr_wdata_o = st_leave(csr_rdata_i);
`endif
        end else begin
          csr_raddr_o = addr_q;
          rdata_d     = csr_rdata_i;
          csr_waddr_o = addr_q;
          // Set/clear with rs1 == x0 (or zimm == 0) is a pure read.
          csr_we_o    = (op_q == OP_RW) || !rs1z_q;
          case (op_q)
            OP_RS:   csr_wdata_o = csr_rdata_i | src_q;
            OP_RC:   csr_wdata_o = csr_rdata_i & ~src_q;
            default: csr_wdata_o = src_q;
          endcase
        end
      end
      TRAP_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = A_MEPC;
        csr_wdata_o = pc_q;
        state_d     = TRAP_CAUSE;
      end
      TRAP_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = A_MCAUSE;
        csr_wdata_o = DATA_W'(ECALL_CAUSE);
        redir_d     = 1'b1;
        rpc_d       = csr_mtvec_i;
`ifdef CSR_MSTATUS_TRAP_EN
        state_d     = TRAP_STATUS;
`else
        state_d     = RESP;
`endif
      end
`ifdef CSR_MSTATUS_TRAP_EN
      TRAP_STATUS: begin
        csr_raddr_o = A_MSTATUS;
        csr_we_o    = 1'b1;
        csr_waddr_o = A_MSTATUS;
        csr_wdata_o = st_enter(csr_rdata_i);
        state_d     = RESP;
      end
`endif
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rs1z_q  <= 1'b0;
      addr_q  <= '0;
      src_q   <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
      redir_q <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
      if (accept) begin
        op_q   <= req_op_i;
        rs1z_q <= req_rs1_zero_i;
        addr_q <= req_addr_i;
        src_q  <= req_src_i;
        pc_q   <= req_pc_i;
      end
    end
  end

  assign resp_valid_o    = (state_q == RESP);
  assign resp_rdata_o    = rdata_q;
  assign resp_redirect_o = redir_q;
  assign resp_pc_o       = rpc_q;

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Initiator side of the single-write-port CSR register-file interface.
- Accepts Zicsr and trap ops (CSRRW/S/C, ECALL, MRET) from the EXU over a valid/ready handshake.
- Sequences the CSR read and write accesses one per cycle, returns the old CSR value for rd, and issues a PC redirect for traps.
- Sits between the EXU and the CSR file; it is the only driver of the CSR file's write/read ports.

Parameters:
ADDR_W, 12, CSR address width (matches `CSR_ADDR_WIDTH)
DATA_W, 32, CSR data width (matches `CSR_DATA_WIDTH)
ECALL_CAUSE, 11, mcause value written on ECALL (M-mode environment call)

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid_i  in  1  EXU request valid
req_ready_o  out  1  controller can accept a request
req_op_i  in  3  001 CSRRW, 010 CSRRS, 011 CSRRC, 100 ECALL, 101 MRET; other codes illegal
req_imm_i  in  1  operand is zero-extended zimm instead of rs1
req_rs1_zero_i  in  1  rs1 index (or zimm) is zero
req_addr_i  in  ADDR_W  target CSR address
req_src_i  in  DATA_W  rs1 value, or zimm zero-extended
req_pc_i  in  DATA_W  PC of the instruction
csr_we_o  out  1  CSR write enable
csr_waddr_o  out  ADDR_W  CSR write address
csr_wdata_o  out  DATA_W  CSR write data
csr_raddr_o  out  ADDR_W  CSR read address
csr_rdata_i  in  DATA_W  CSR read data, combinational from csr_raddr_o
csr_mtvec_i  in  DATA_W  current MTVEC
csr_mepc_i  in  DATA_W  current MEPC
resp_valid_o  out  1  response valid
resp_ready_i  in  1  EXU accepts the response
resp_rdata_o  out  DATA_W  old CSR value for rd; 0 for ECALL, MRET and illegal ops
resp_redirect_o  out  1  response carries a PC redirect
resp_pc_o  out  DATA_W  redirect target

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including csr_we_o, resp_valid_o and resp_redirect_o, all addresses and data; req_ready_o is 1 once in IDLE.
  - csr_we_o drops immediately when reset asserts, mid-sequence. No partial sequence resumes after reset releases.
- req_ready_o = (state == IDLE). A request is accepted on a cycle where req_valid_i && req_ready_o; all req_* fields are registered at acceptance.
- States: IDLE, EXEC, TRAP_EPC, TRAP_CAUSE, [TRAP_STATUS], RESP.
- CSR ops (001/010/011):
  - IDLE -> EXEC.
  - In EXEC: csr_raddr_o = addr. Old value = csr_rdata_i, captured into resp_rdata_o.
  - New value: RW = src; RS = old | src; RC = old & ~src.
  - Write: csr_we_o=1, waddr = addr, wdata = new value, for exactly that one EXEC cycle.
  - No write for RS/RC when req_rs1_zero_i=1. CSRRW always writes.
  - EXEC -> RESP.
- ECALL:
  - IDLE -> TRAP_EPC: we=1, waddr=MEPC (0x341), wdata=pc.
  - -> TRAP_CAUSE: we=1, waddr=MCAUSE (0x342), wdata=ECALL_CAUSE.
  - -> RESP with resp_redirect_o=1, resp_pc_o=csr_mtvec_i sampled in TRAP_CAUSE.
- MRET: IDLE -> EXEC. No write, unless the optional feature is enabled. resp_pc_o = csr_mepc_i sampled in EXEC; resp_redirect_o=1. -> RESP.
- Illegal op: IDLE -> RESP. No CSR access, resp_rdata_o=0, resp_redirect_o=0.
- RESP:
  - resp_valid_o=1 and all resp_* fields are held stable until resp_ready_i.
  - On resp_valid_o && resp_ready_i -> IDLE.
  - Back-to-back throughput is one new request per IDLE cycle (no accept during RESP).
- csr_raddr_o = 0 and csr_we_o = 0 in every state not listed above as driving them.
- Widths: all arithmetic is DATA_W bits, no sign extension. zimm is zero-extended upstream.

Optional Feature:
CSR_MSTATUS_TRAP_EN
- Defined:
  - ECALL inserts TRAP_STATUS after TRAP_CAUSE. raddr=MSTATUS (0x300); we=1 with wdata = rdata with MPIE(bit7)=MIE(bit3), MIE=0, MPP(12:11)=2'b11.
  - MRET in EXEC writes MSTATUS: MIE=MPIE, MPIE=1, MPP=2'b11.
  - Resulting ECALL request-to-resp_valid latency is 4 cycles.
- Undefined:
  - MSTATUS is never written by traps; TRAP_STATUS does not exist.
  - ECALL request-to-resp_valid latency is 3 cycles.

Test Plan:
- CSRRW mtvec (0x305), src=0x80000100, old=0 -> one EXEC cycle with we=1, waddr=0x305, wdata=0x80000100; resp_rdata_o=0; resp_valid 2 cycles after accept.
- CSRRS mstatus, old=0x1800, src=0x8 -> wdata=0x1808, resp_rdata=0x1800; repeat with req_rs1_zero_i=1 -> csr_we_o never high, resp_rdata=0x1800.
- ECALL pc=0x80000040, mtvec=0x80000100 -> writes mepc=0x80000040 then mcause=11 on consecutive cycles; resp_redirect=1, resp_pc=0x80000100.
- MRET with mepc=0x80000044 -> resp_redirect=1, resp_pc=0x80000044; no write (macro undefined); with macro, mstatus 0x80 -> 0x1888.
- resp_ready_i held low 5 cycles -> resp fields stable, req_ready_o=0, csr_we_o=0 throughout.
- reset asserted during TRAP_CAUSE -> csr_we_o falls asynchronously, resp_valid_o=0, IDLE after release, mcause unchanged.
